// File: rtl/button_conditioner_pkg.sv
// Shared colour codes, conditioner FSM states and small helpers for the button path.
package button_conditioner_pkg;

  localparam logic [1:0] COL_0 = 2'b00;
  localparam logic [1:0] COL_1 = 2'b01;
  localparam logic [1:0] COL_2 = 2'b10;
  localparam logic [1:0] COL_3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HELD     = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Same bit-to-colour map as the colour decoder; only called with a one-hot value.
  function automatic logic [1:0] enc_colour(input logic [3:0] onehot);
    logic [1:0] col;
    case (onehot)
      4'b0001: col = COL_0;
      4'b0010: col = COL_1;
      4'b0100: col = COL_2;
      4'b1000: col = COL_3;
      default: col = COL_0;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchroniser bank for asynchronous inputs, asynchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and chord-filters four raw colour buttons into one press pulse per press.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn_raw,
  output logic       press_valid,
  output logic [1:0] press_colour,
  output logic       btn_held,
  output logic       chord_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       btn_sync;
  logic [2:0]       btn_count;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             press_valid_q, press_valid_d;
  logic [1:0]       press_colour_q, press_colour_d;
  logic             chord_err_q, chord_err_d;
  logic             btn_held_q, btn_held_d;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  assign btn_count = popcount4(btn_sync);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cand_d         = cand_q;
    press_valid_d  = 1'b0;
    press_colour_d = press_colour_q;
    chord_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_count == 3'd1) begin
          cand_d  = btn_sync;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_DEBOUNCE;
        end else if (btn_count != 3'd0) begin
          chord_err_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_LOCKOUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (btn_sync != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Acceptance consumes the press even when reporting is disabled.
          state_d        = ST_HELD;
          press_valid_d  = en;
          press_colour_d = en ? enc_colour(cand_q) : press_colour_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (btn_sync == 4'b0000) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (btn_sync != 4'b0000) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (btn_sync != 4'b0000) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    btn_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= {CNT_W{1'b0}};
      cand_q         <= 4'b0000;
      press_valid_q  <= 1'b0;
      press_colour_q <= 2'b00;
      chord_err_q    <= 1'b0;
      btn_held_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cand_q         <= cand_d;
      press_valid_q  <= press_valid_d;
      press_colour_q <= press_colour_d;
      chord_err_q    <= chord_err_d;
      btn_held_q     <= btn_held_d;
    end
  end

  assign press_valid  = press_valid_q;
  assign press_colour = press_colour_q;
  assign chord_err    = chord_err_q;
  assign btn_held     = btn_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int PRESS_LAT = DEB + 3;
  localparam int CHORD_LAT = 3;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] colour;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] btn_raw;
  logic       press_valid;
  logic [1:0] press_colour;
  logic       btn_held;
  logic       chord_err;

  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t sb_q[$];

  button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .btn_raw      (btn_raw),
    .press_valid  (press_valid),
    .press_colour (press_colour),
    .btn_held     (btn_held),
    .chord_err    (chord_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_press(input logic [1:0] col);
    exp_t e;
    e.kind   = 2'b01;
    e.colour = col;
    e.cyc    = cyc + PRESS_LAT;
    sb_q.push_back(e);
  endtask

  task automatic push_chord();
    exp_t e;
    e.kind   = 2'b10;
    e.colour = 2'b00;
    e.cyc    = cyc + CHORD_LAT;
    sb_q.push_back(e);
  endtask

  // Output monitor: every pulse must match the oldest expected event, including its cycle.
  always @(negedge clk) begin
    if (press_valid || chord_err) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, chord_err, press_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("pulse_kind", {30'd0, chord_err, press_valid}, {30'd0, e.kind});
        check_eq("pulse_cycle", cyc, e.cyc);
        if (e.kind == 2'b01) check_eq("press_colour", {30'd0, press_colour}, {30'd0, e.colour});
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    en      = 1'b1;
    btn_raw = 4'b0000;
    wait_cycles(3);
    check_eq("rst_press_valid", {31'd0, press_valid}, 32'd0);
    check_eq("rst_press_colour", {30'd0, press_colour}, 32'd0);
    check_eq("rst_btn_held", {31'd0, btn_held}, 32'd0);
    check_eq("rst_chord_err", {31'd0, chord_err}, 32'd0);
    rst = 1'b0;
    wait_cycles(4);
    check_eq("idle_btn_held", {31'd0, btn_held}, 32'd0);

    // Single clean press of bit2, then release timing of btn_held.
    btn_raw = 4'b0100;
    push_press(2'b10);
    wait_cycles(12);
    check_eq("held_level", {31'd0, btn_held}, 32'd1);
    btn_raw = 4'b0000;
    wait_cycles(6);
    check_eq("release_still_held", {31'd0, btn_held}, 32'd1);
    wait_cycles(1);
    check_eq("release_done", {31'd0, btn_held}, 32'd0);
    wait_cycles(6);

    // Bounce on bit0 before a stable press.
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      wait_cycles(1);
    end
    btn_raw = 4'b0001;
    push_press(2'b00);
    wait_cycles(12);
    btn_raw = 4'b0000;
    wait_cycles(12);

    // Chord, then a single button without release, then release and re-press.
    btn_raw = 4'b0011;
    push_chord();
    wait_cycles(8);
    btn_raw = 4'b0010;
    wait_cycles(10);
    btn_raw = 4'b0000;
    wait_cycles(8);
    btn_raw = 4'b0010;
    push_press(2'b01);
    wait_cycles(12);
    btn_raw = 4'b0000;
    wait_cycles(12);

    // Acceptance with reporting disabled is swallowed even after en rises.
    en      = 1'b0;
    btn_raw = 4'b1000;
    wait_cycles(9);
    en = 1'b1;
    wait_cycles(8);
    check_eq("silent_held", {31'd0, btn_held}, 32'd1);
    btn_raw = 4'b0000;
    wait_cycles(12);
    btn_raw = 4'b1000;
    push_press(2'b11);
    wait_cycles(12);
    btn_raw = 4'b0000;
    wait_cycles(12);

    // Two sequential presses with a short release glitch inside the first.
    btn_raw = 4'b0001;
    push_press(2'b00);
    wait_cycles(10);
    btn_raw = 4'b0000;
    wait_cycles(2);
    btn_raw = 4'b0001;
    wait_cycles(6);
    check_eq("glitch_held", {31'd0, btn_held}, 32'd1);
    btn_raw = 4'b0000;
    wait_cycles(10);
    btn_raw = 4'b1000;
    push_press(2'b11);
    wait_cycles(12);
    btn_raw = 4'b0000;
    wait_cycles(12);

    // Asynchronous reset while a press is held; the held button then re-debounces.
    btn_raw = 4'b0100;
    push_press(2'b10);
    wait_cycles(12);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_btn_held", {31'd0, btn_held}, 32'd0);
    check_eq("async_rst_colour", {30'd0, press_colour}, 32'd0);
    check_eq("async_rst_valid", {31'd0, press_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_press(2'b10);
    wait_cycles(12);
    check_eq("post_rst_held", {31'd0, btn_held}, 32'd1);
    btn_raw = 4'b0000;
    wait_cycles(20);

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
